// File: rtl/disp_pkg.sv
// Shared display definitions: digit count, segment width, blink phase and the
// blank-segment helper used by the scan driver.
package disp_pkg;

   localparam int unsigned NUM_DIGITS = 6;
   localparam int unsigned SEG_W      = 8;
   localparam int unsigned DIG_W      = 3;

   typedef enum logic {
      VISIBLE = 1'b0,
      HIDDEN  = 1'b1
   } phase_e;

   // All segments at their OFF level for the given pin polarity.
   function automatic logic [SEG_W-1:0] seg_blank(input logic active_low);
      return active_low ? {SEG_W{1'b1}} : {SEG_W{1'b0}};
   endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD free-running counter with synchronous clear.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   clr       synchronous clear to 0, overrides en
//   en        count enable
//   cnt       current count 0..MOD-1
//   wrap      high in the cycle the count steps MOD-1 -> 0
module mod_counter #(
   parameter int unsigned MOD = 4,
   parameter int unsigned W   = (MOD > 1) ? $clog2(MOD) : 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] cnt,
   output logic         wrap
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   assign wrap = en & ~clr & (cnt_q == W'(MOD - 1));
   assign cnt  = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = wrap ? '0 : cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/seg_scan.sv
// Time-multiplexed 6-digit seven-segment driver with per-digit blink.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   seg_in      packed segment image, digit d = seg_in[d*8+:8], digit 5 leftmost
//   blink_en    bit d set -> digit d blinks
//   an          digit enables, at most one ON
//   seg         segment pattern {dp,g..a} of the active digit
//   cur_digit   digit currently owning the scan slot
//   frame_tick  one-cycle pulse when cur_digit wraps 5 -> 0
module seg_scan
   import disp_pkg::*;
#(
   parameter int unsigned SCAN_DIV   = 1000,
   parameter int unsigned BLANK_CYC  = 2,
   parameter int unsigned BLINK_DIV  = 250000,
   parameter bit          ACTIVE_LOW = 1'b1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_DIGITS*SEG_W-1:0] seg_in,
   input  logic [NUM_DIGITS-1:0]       blink_en,
   output logic [NUM_DIGITS-1:0]       an,
   output logic [SEG_W-1:0]            seg,
   output logic [DIG_W-1:0]            cur_digit,
   output logic                        frame_tick
);

   localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [SEG_W-1:0]      BLANK_SEG = seg_blank(ACTIVE_LOW);
   localparam logic [NUM_DIGITS-1:0] AN_OFF    = {NUM_DIGITS{ACTIVE_LOW}};
   localparam logic [DIG_W-1:0]      LAST_DIG  = DIG_W'(NUM_DIGITS - 1);

   if (BLANK_CYC >= SCAN_DIV) begin : g_bad_blank
      $error("seg_scan: BLANK_CYC must be smaller than SCAN_DIV");
   end

   logic [SW-1:0]         scan_cnt;
   logic                  scan_wrap;
   logic [BW-1:0]         unused_blink_cnt;
   logic                  blink_wrap;
   logic                  blink_entry_c;
   logic                  guard_c;

   logic [DIG_W-1:0]      cur_digit_q,  cur_digit_d;
   logic                  frame_tick_q, frame_tick_d;
   logic [NUM_DIGITS-1:0] an_q,         an_d;
   logic [SEG_W-1:0]      seg_q,        seg_d;
   logic [SEG_W-1:0]      lat_byte_q,   lat_byte_d;
   logic                  lat_blink_q,  lat_blink_d;
   logic [NUM_DIGITS-1:0] blink_prev_q, blink_prev_d;
   phase_e                phase_q,      phase_d;

   logic [SEG_W-1:0]      slot_byte_c, disp_byte_c;
   logic                  slot_blink_c, disp_blink_c;
   phase_e                phase_eff_c;
   logic [NUM_DIGITS-1:0] onehot_c;

   mod_counter #(.MOD(SCAN_DIV), .W(SW)) u_scan_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (1'b0),
      .en   (1'b1),
      .cnt  (scan_cnt),
      .wrap (scan_wrap)
   );

   mod_counter #(.MOD(BLINK_DIV), .W(BW)) u_blink_cnt (
      .clk  (clk),
      .rst  (rst),
      .clr  (blink_entry_c),
      .en   (1'b1),
      .cnt  (unused_blink_cnt),
      .wrap (blink_wrap)
   );

   // Entering edit mode restarts the blink so the field starts out visible.
   assign blink_entry_c = (blink_prev_q == '0) && (blink_en != '0);

   // Anti-ghost window at the start of every slot.
   if (BLANK_CYC == 0) begin : g_no_guard
      assign guard_c = 1'b0;
   end else begin : g_guard
      assign guard_c = (32'(scan_cnt) < BLANK_CYC);
   end

   // Next-state and output decode.
   always_comb begin
      cur_digit_d  = cur_digit_q;
      frame_tick_d = 1'b0;
      an_d         = AN_OFF;
      seg_d        = BLANK_SEG;
      lat_byte_d   = lat_byte_q;
      lat_blink_d  = lat_blink_q;
      blink_prev_d = blink_en;
      phase_d      = phase_q;

      slot_byte_c  = seg_in[{cur_digit_q, 3'b000} +: SEG_W];
      slot_blink_c = blink_en[cur_digit_q];
      onehot_c     = NUM_DIGITS'(1) << cur_digit_q;

      // Slot latch; the bypass keeps BLANK_CYC=0 showing the new digit at once.
      if (scan_cnt == '0) begin
         lat_byte_d   = slot_byte_c;
         lat_blink_d  = slot_blink_c;
         disp_byte_c  = slot_byte_c;
         disp_blink_c = slot_blink_c;
      end else begin
         disp_byte_c  = lat_byte_q;
         disp_blink_c = lat_blink_q;
      end

      phase_eff_c = blink_entry_c ? VISIBLE : phase_q;
      if (blink_entry_c) begin
         phase_d = VISIBLE;
      end else if (blink_wrap) begin
         phase_d = (phase_q == VISIBLE) ? HIDDEN : VISIBLE;
      end

      if (scan_wrap) begin
         cur_digit_d  = (cur_digit_q == LAST_DIG) ? '0 : cur_digit_q + DIG_W'(1);
         frame_tick_d = (cur_digit_q == LAST_DIG);
      end

      // Blinked digit keeps its anode so brightness of neighbours is unchanged.
      if (!guard_c) begin
         an_d  = AN_OFF ^ onehot_c;
         seg_d = (disp_blink_c && (phase_eff_c == HIDDEN)) ? BLANK_SEG : disp_byte_c;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_digit_q  <= '0;
         frame_tick_q <= 1'b0;
         an_q         <= AN_OFF;
         seg_q        <= BLANK_SEG;
         lat_byte_q   <= BLANK_SEG;
         lat_blink_q  <= 1'b0;
         blink_prev_q <= '0;
         phase_q      <= VISIBLE;
      end else begin
         cur_digit_q  <= cur_digit_d;
         frame_tick_q <= frame_tick_d;
         an_q         <= an_d;
         seg_q        <= seg_d;
         lat_byte_q   <= lat_byte_d;
         lat_blink_q  <= lat_blink_d;
         blink_prev_q <= blink_prev_d;
         phase_q      <= phase_d;
      end
   end

   assign an         = an_q;
   assign seg        = seg_q;
   assign cur_digit  = cur_digit_q;
   assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan with SCAN_DIV=4, BLANK_CYC=1, BLINK_DIV=16, active-low pins.
// A cycle model pushes the expected lit-digit outputs into a queue; a monitor
// pops one entry for every cycle the DUT drives an anode.
module tb_seg_scan;

   localparam int unsigned SCAN_DIV  = 4;
   localparam int unsigned BLANK_CYC = 1;
   localparam int unsigned BLINK_DIV = 16;
   localparam int unsigned FRAME     = SCAN_DIV * 6;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [47:0] seg_in;
   logic [5:0]  blink_en;
   logic [5:0]  an;
   logic [7:0]  seg;
   logic [2:0]  cur_digit;
   logic        frame_tick;

   seg_scan #(
      .SCAN_DIV   (SCAN_DIV),
      .BLANK_CYC  (BLANK_CYC),
      .BLINK_DIV  (BLINK_DIV),
      .ACTIVE_LOW (1'b1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .seg_in     (seg_in),
      .blink_en   (blink_en),
      .an         (an),
      .seg        (seg),
      .cur_digit  (cur_digit),
      .frame_tick (frame_tick)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [5:0] an;
      logic [7:0] seg;
      logic       tick;
      logic [2:0] dig;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   // Reference model state
   int         p = 0;
   int         q = 0;
   logic [7:0] m_byte[6];
   logic       m_blk[6];
   logic [5:0] m_prev = '0;
   bit         m_hidden = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Cycle model: p counts clock edges since reset release.
   always @(posedge clk) begin
      if (rst) begin
         p = 0;
         q = 0;
         m_prev = '0;
      end else begin
         int   r, d;
         exp_t e;
         p++;
         if (blink_en != 6'd0 && m_prev == 6'd0) q = p;
         m_prev = blink_en;
         r = (p - 1) % SCAN_DIV;
         d = ((p - 1) / SCAN_DIV) % 6;
         m_hidden = (p > q) && ((((p - q - 1) / BLINK_DIV) % 2) == 1);
         if (r < BLANK_CYC) begin
            m_byte[d] = seg_in[d*8 +: 8];
            m_blk[d]  = blink_en[d];
         end else begin
            e.an   = ~(6'b000001 << d);
            e.seg  = (m_blk[d] && m_hidden) ? 8'hFF : m_byte[d];
            e.tick = ((p % FRAME) == 0);
            e.dig  = 3'((p / SCAN_DIV) % 6);
            exp_q.push_back(e);
         end
      end
   end

   // Monitor: one-hot every cycle, scoreboard compare on every lit cycle.
   always @(negedge clk) begin
      if (!rst) begin
         exp_t e;
         tests++;
         if ($countones(~an) > 1) begin
            fails++;
            $display("FAIL onehot: an=%h at p=%0d", an, p);
         end
         if (an != 6'h3F) begin
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_lit: an=%h seg=%h at p=%0d", an, seg, p);
            end else begin
               e = exp_q.pop_front();
               if ({an, seg, frame_tick, cur_digit} !== e) begin
                  fails++;
                  $display("FAIL scan p=%0d: got an=%h seg=%h tick=%b dig=%0d expected an=%h seg=%h tick=%b dig=%0d",
                           p, an, seg, frame_tick, cur_digit, e.an, e.seg, e.tick, e.dig);
               end
            end
         end
      end
   end

   initial begin
      logic [5:0] tbl[6];
      logic [5:0] prev_an;
      int n, hid_cnt, vis_cnt, bad0;
      tbl[0] = 6'h3E; tbl[1] = 6'h3D; tbl[2] = 6'h3B;
      tbl[3] = 6'h37; tbl[4] = 6'h2F; tbl[5] = 6'h1F;
      for (int d = 0; d < 6; d++) seg_in[d*8 +: 8] = 8'hC0 + 8'(d);
      blink_en = '0;

      // Power-on reset
      #1 rst = 1'b1;
      #1;
      chk("rst_an", 32'(an), 32'h3F);
      chk("rst_seg", 32'(seg), 32'hFF);
      chk("rst_digit", 32'(cur_digit), 32'd0);
      chk("rst_tick", 32'(frame_tick), 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Scan order after a frame boundary
      n = 0;
      do begin @(negedge clk); n++; end while (!frame_tick && n < 100);
      chk("first_tick_seen", 32'(frame_tick), 32'd1);
      prev_an = an;
      for (int k = 0; k < 6; k++) begin
         n = 0;
         do begin @(negedge clk); n++; end while ((an == 6'h3F || an == prev_an) && n < 20);
         chk("order_an", 32'(an), 32'(tbl[k]));
         chk("order_seg", 32'(seg), 32'hC0 + 32'(k));
         prev_an = an;
      end
      n = 0;
      do begin @(negedge clk); n++; end while (!frame_tick && n < 100);
      n = 0;
      do begin @(negedge clk); n++; end while (!frame_tick && n < 100);
      chk("frame_period", 32'(n), 32'(FRAME));

      // Asynchronous reset in the middle of digit 3's slot
      n = 0;
      do begin @(negedge clk); n++; end while (cur_digit != 3'd3 && n < 100);
      #2 rst = 1'b1;
      #1;
      chk("midrst_an", 32'(an), 32'h3F);
      chk("midrst_seg", 32'(seg), 32'hFF);
      chk("midrst_digit", 32'(cur_digit), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_c1_an", 32'(an), 32'h3F);
      @(negedge clk);
      chk("post_rst_c2_an", 32'(an), 32'h3E);
      chk("post_rst_c2_seg", 32'(seg), 32'hC0);

      // Tearing: change digit 1's byte while it is on display
      n = 0;
      do begin @(negedge clk); n++; end while (an != 6'h3D && n < 100);
      seg_in[15:8] = 8'h5A;
      @(negedge clk);
      chk("tear_hold_an", 32'(an), 32'h3D);
      chk("tear_hold_seg", 32'(seg), 32'hC1);
      n = 0;
      do begin @(negedge clk); n++; end while (an == 6'h3D && n < 100);
      n = 0;
      do begin @(negedge clk); n++; end while (an != 6'h3D && n < 100);
      chk("tear_new_seg", 32'(seg), 32'h5A);

      // Blink digits 5 and 4
      blink_en = 6'b110000;
      hid_cnt = 0; vis_cnt = 0; bad0 = 0;
      repeat (128) begin
         @(negedge clk);
         if (an == 6'h1F && seg == 8'hFF) hid_cnt++;
         if (an == 6'h1F && seg == 8'hC5) vis_cnt++;
         if (an == 6'h3E && seg != 8'hC0) bad0++;
      end
      chk("blink_hidden_seen", 32'(hid_cnt > 0), 32'd1);
      chk("blink_visible_seen", 32'(vis_cnt > 0), 32'd1);
      chk("blink_digit0_steady", 32'(bad0), 32'd0);

      // Phase restart on entering edit while HIDDEN, then field move
      blink_en = '0;
      n = 0;
      do begin
         @(negedge clk); n++;
      end while (!(m_hidden && (((p - q - 1) % BLINK_DIV) < 8)) && n < 200);
      chk("hidden_reached", 32'(m_hidden), 32'd1);
      blink_en = 6'b000011;
      repeat (40) @(negedge clk);
      blink_en = 6'b001100;
      repeat (80) @(negedge clk);
      blink_en = '0;
      repeat (60) @(negedge clk);

      // Random soak
      for (int i = 0; i < 10000; i++) begin
         @(negedge clk);
         seg_in = {16'($urandom), $urandom};
         if ((i % 37) == 0) blink_en = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom);
      end

      @(negedge clk);
      #1;
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
